baud_rate_gen: RTL and testbench

Parametrised fractional baud-rate generator for the UART. A phase accumulator produces an oversample tick at any rate up to f_clk, with a runtime-loadable increment. An oversample counter derives a per-bit tick and a mid-bit sample tick. Feeds both the UART transmitter (bit_tick) and the receiver (os_tick, mid_tick, resync on start-bit edge).

---
 rtl/baud_rate_gen_if.sv | 24 ++
 rtl/baud_rate_gen.sv | 75 +++++++
 tb/tb_baud_rate_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/baud_rate_gen_if.sv
// Control and tick bundle between the baud-rate generator and its UART client.
// The master drives enable/increment/resync; the slave (generator) drives the ticks.
interface baud_rate_gen_if #(
    parameter int ACC_WIDTH = 16
);
    logic                 en;
    logic [ACC_WIDTH-1:0] inc_in;
    logic                 inc_load;
    logic                 resync;
    logic                 os_tick;
    logic                 mid_tick;
    logic                 bit_tick;
    logic [ACC_WIDTH-1:0] inc_cur;

    modport master (
        output en, inc_in, inc_load, resync,
        input  os_tick, mid_tick, bit_tick, inc_cur
    );

    modport slave (
        input  en, inc_in, inc_load, resync,
        output os_tick, mid_tick, bit_tick, inc_cur
    );
endinterface

// File: rtl/baud_rate_gen.sv
// Fractional baud-rate generator: a phase accumulator produces oversample ticks,
// and an oversample counter derives mid-bit and end-of-bit ticks from them.
module baud_rate_gen #(
    parameter int ACC_WIDTH   = 16,
    parameter int OSR         = 8,
    parameter int DEFAULT_INC = 604
) (
    input  logic            clk,
    input  logic            rst,
    baud_rate_gen_if.slave  bus
);
    localparam int OS_W = $clog2(OSR);
    localparam logic [OS_W-1:0]      MID_CNT  = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]      LAST_CNT = OS_W'(OSR - 1);
    localparam logic [ACC_WIDTH-1:0] INC_RST  = ACC_WIDTH'(DEFAULT_INC);

    logic [ACC_WIDTH-1:0] acc_reg;
    logic [ACC_WIDTH-1:0] inc_reg;
    logic [OS_W-1:0]      os_cnt_reg;
    logic                 os_tick_reg;
    logic                 mid_tick_reg;
    logic                 bit_tick_reg;

    logic [ACC_WIDTH:0]   sum_next;
    logic                 carry_next;
    logic [OS_W-1:0]      os_cnt_next;

    // The add always uses the increment held before this edge, so a load never
    // jumps the phase and only affects the following add.
    always_comb begin
        sum_next    = {1'b0, acc_reg} + {1'b0, inc_reg};
        carry_next  = sum_next[ACC_WIDTH];
        os_cnt_next = os_cnt_reg;
        if (carry_next) begin
            os_cnt_next = (os_cnt_reg == LAST_CNT) ? '0 : os_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            inc_reg      <= INC_RST;
            os_cnt_reg   <= '0;
            os_tick_reg  <= 1'b0;
            mid_tick_reg <= 1'b0;
            bit_tick_reg <= 1'b0;
        end else begin
            if (bus.inc_load) begin
                inc_reg <= bus.inc_in;
            end
            if (bus.resync) begin
                acc_reg      <= '0;
                os_cnt_reg   <= '0;
                os_tick_reg  <= 1'b0;
                mid_tick_reg <= 1'b0;
                bit_tick_reg <= 1'b0;
            end else if (bus.en) begin
                acc_reg      <= sum_next[ACC_WIDTH-1:0];
                os_cnt_reg   <= os_cnt_next;
                os_tick_reg  <= carry_next;
                mid_tick_reg <= carry_next && (os_cnt_reg == MID_CNT);
                bit_tick_reg <= carry_next && (os_cnt_reg == LAST_CNT);
            end else begin
                os_tick_reg  <= 1'b0;
                mid_tick_reg <= 1'b0;
                bit_tick_reg <= 1'b0;
            end
        end
    end

    assign bus.os_tick  = os_tick_reg;
    assign bus.mid_tick = mid_tick_reg;
    assign bus.bit_tick = bit_tick_reg;
    assign bus.inc_cur  = inc_reg;
endmodule

// File: tb/tb_baud_rate_gen.sv
// Bench for baud_rate_gen: a total-phase model predicts every tick each cycle,
// plus directed runs with hand-computed tick counts.
module tb_baud_rate_gen;
    localparam int ACC_WIDTH = 16;
    localparam int OSR       = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    baud_rate_gen_if #(.ACC_WIDTH(ACC_WIDTH)) b ();

    baud_rate_gen #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OSR        (OSR),
        .DEFAULT_INC(604)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: unbounded phase since last zeroing; os_tick number k is the count of
    // whole 2^ACC_WIDTH wraps, mid on k%OSR==OSR/2, bit on k%OSR==0.
    longint unsigned phase;
    longint unsigned inc_m;
    bit exp_os, exp_mid, exp_bit;
    longint unsigned exp_inc;

    always @(posedge clk) begin
        longint unsigned old_inc, k0, k1;
        if (rst) begin
            phase = 0; inc_m = 604;
            exp_os = 0; exp_mid = 0; exp_bit = 0;
        end else begin
            old_inc = inc_m;
            if (b.inc_load) inc_m = longint'(b.inc_in);
            if (b.resync) begin
                phase = 0;
                exp_os = 0; exp_mid = 0; exp_bit = 0;
            end else if (b.en) begin
                k0 = phase >> ACC_WIDTH;
                phase = phase + old_inc;
                k1 = phase >> ACC_WIDTH;
                exp_os  = (k1 != k0);
                exp_mid = exp_os && ((k1 % OSR) == OSR / 2);
                exp_bit = exp_os && ((k1 % OSR) == 0);
            end else begin
                exp_os = 0; exp_mid = 0; exp_bit = 0;
            end
        end
        exp_inc = inc_m;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("os_tick",  longint'(b.os_tick),  longint'(exp_os));
            chk("mid_tick", longint'(b.mid_tick), longint'(exp_mid));
            chk("bit_tick", longint'(b.bit_tick), longint'(exp_bit));
            chk("inc_cur",  longint'(b.inc_cur),  longint'(exp_inc));
        end
    end

    task automatic run_count(input int n, output int os, output int mid, output int bt);
        os = 0; mid = 0; bt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            os  += int'(b.os_tick);
            mid += int'(b.mid_tick);
            bt  += int'(b.bit_tick);
        end
    endtask

    task automatic load_and_resync(input int val);
        b.inc_in = ACC_WIDTH'(val); b.inc_load = 1'b1; b.resync = 1'b1;
        @(negedge clk);
        b.inc_load = 1'b0; b.resync = 1'b0;
    endtask

    initial begin
        int edges, os, mid, bt;
        b.en = 1'b0; b.inc_in = '0; b.inc_load = 1'b0; b.resync = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_inc_cur", longint'(b.inc_cur), 604);
        chk("reset_os_tick", longint'(b.os_tick), 0);
        $display("reset: inc_cur=%0d os_tick=%0d", b.inc_cur, b.os_tick);

        rst = 1'b0; b.en = 1'b1;
        edges = 0;
        while (edges < 200) begin
            @(negedge clk);
            edges++;
            if (b.os_tick) break;
        end
        chk("first_os_edges", edges, 109);
        $display("first os_tick after %0d enabled edges", edges);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_pulse_os", longint'(b.os_tick), 0);
        run_count(10000, os, mid, bt);
        chk("run10k_os", os, 92);
        chk("run10k_mid", mid, 12);
        chk("run10k_bit", bt, 11);
        $display("10000 edges @604: os=%0d mid=%0d bit=%0d", os, mid, bt);

        b.inc_in = 16'd1208; b.inc_load = 1'b1;
        @(negedge clk);
        b.inc_load = 1'b0;
        chk("load_inc_cur", longint'(b.inc_cur), 1208);
        $display("inc_load 1208: inc_cur=%0d", b.inc_cur);

        b.en = 1'b0;
        run_count(500, os, mid, bt);
        chk("en_low_os", os, 0);
        $display("en low 500 cycles: os=%0d", os);
        b.en = 1'b1;

        load_and_resync(0);
        run_count(2000, os, mid, bt);
        chk("inc0_os", os, 0);
        $display("inc 0, 2000 edges: os=%0d", os);

        load_and_resync(65535);
        run_count(1000, os, mid, bt);
        chk("incmax_os", os, 999);
        chk("incmax_bit", bt, 124);
        $display("inc 65535, 1000 edges: os=%0d bit=%0d", os, bt);

        load_and_resync(604);
        for (int i = 0; i < 20000; i++) begin
            b.en       = ($urandom % 8) != 0;
            b.resync   = ($urandom % 250) == 0;
            b.inc_load = ($urandom % 400) == 0;
            case ($urandom % 6)
                0:       b.inc_in = 16'd0;
                1:       b.inc_in = 16'd65535;
                default: b.inc_in = ACC_WIDTH'($urandom_range(1, 9000));
            endcase
            rst = ($urandom % 3000) == 0;
            @(negedge clk);
        end
        rst = 1'b0; b.resync = 1'b0; b.inc_load = 1'b0;
        @(negedge clk);
        $display("random phase done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
